// File: rtl/axil_lfsr_stream_gen_pkg.sv
// axil_lfsr_pkg: register map, CTRL bit indices, AXI response codes and generator FSM states
package axil_lfsr_pkg;

    localparam logic [31:0] ADDR_CTRL   = 32'h00;
    localparam logic [31:0] ADDR_SEED   = 32'h04;
    localparam logic [31:0] ADDR_TAPS   = 32'h08;
    localparam logic [31:0] ADDR_COUNT  = 32'h0C;
    localparam logic [31:0] ADDR_STATUS = 32'h10;
    localparam logic [31:0] ADDR_TOTAL  = 32'h14;

    localparam int CTRL_START = 0;
    localparam int CTRL_STOP  = 1;
    localparam int CTRL_MODE  = 2;
    localparam int CTRL_CONT  = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} gen_state_t;

    // Writable addresses; TOTAL only exists when the stats counter is built in
    function automatic logic wr_addr_ok(input logic [31:0] a, input logic stats);
        return a == ADDR_CTRL || a == ADDR_SEED || a == ADDR_TAPS || a == ADDR_COUNT ||
               (stats && a == ADDR_TOTAL);
    endfunction

    // Readable addresses add the read-only STATUS register
    function automatic logic rd_addr_ok(input logic [31:0] a, input logic stats);
        return wr_addr_ok(a, stats) || a == ADDR_STATUS;
    endfunction

endpackage

// File: rtl/axil_lfsr_stream_gen_if.sv
// axil_if / axis_if: AXI-Lite register bus and AXI-Stream beat bundles with master/slave views
interface axil_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

interface axis_if #(
    parameter int DW = 32
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    modport master (output tdata, tvalid, tlast, input tready);
    modport slave (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axil_lfsr_stream_gen_lfsr_core.sv
// lfsr_core: combinational LFSR step, Fibonacci (mode 0) or Galois (mode 1), shared with checker-side PRBS logic
module lfsr_core #(
    parameter int LFSR_W = 8
) (
    input  logic [LFSR_W-1:0] state,
    input  logic [LFSR_W-1:0] taps,
    input  logic              mode,
    output logic [LFSR_W-1:0] next
);

    assign next = mode ? ((state >> 1) ^ ({LFSR_W{state[0]}} & taps))
                       : {state[LFSR_W-2:0], ^(state & taps)};

endmodule

// File: rtl/axil_lfsr_stream_gen.sv
// axil_lfsr_stream_gen: AXI-Lite configured LFSR source streaming counted or free-run bursts; AXIL_LFSR_STATS_EN adds TOTAL at 0x14
module axil_lfsr_stream_gen
    import axil_lfsr_pkg::*;
#(
    parameter int          LFSR_W            = 8,
    parameter logic [31:0] TAPS_RST          = 32'h0000_00B8,
    parameter int          CNT_W             = 16,
    parameter int          C_AXIL_ADDR_WIDTH = 5,
    parameter int          C_AXIL_DATA_WIDTH = 32,
    parameter int          C_AXIS_DATA_WIDTH = 32
) (
    input logic    aclk,
    input logic    areset,
    axil_if.slave  s_axi,
    axis_if.master m_axis
);

`ifdef AXIL_LFSR_STATS_EN
    localparam logic STATS_EN = 1'b1;
`else
    localparam logic STATS_EN = 1'b0;
`endif

    localparam logic [LFSR_W-1:0] TAPS_INIT = TAPS_RST[LFSR_W-1:0];

    logic [C_AXIL_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [C_AXIL_DATA_WIDTH-1:0] w_data_q, w_data_d, rdata_q, rdata_d;
    logic                         aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic                         awready_q, awready_d, wready_q, wready_d;
    logic                         bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
    logic [1:0]                   bresp_q, bresp_d, rresp_q, rresp_d;
    logic [LFSR_W-1:0]            seed_q, seed_d, taps_q, taps_d, run_taps_q, run_taps_d;
    logic [LFSR_W-1:0]            lfsr_q, lfsr_d, lfsr_nx;
    logic [CNT_W-1:0]             count_q, count_d, run_count_q, run_count_d, beats_q, beats_d;
    logic                         mode_q, mode_d, cont_q, cont_d, cfg_err_q, cfg_err_d;
    logic                         run_mode_q, run_mode_d, run_cont_q, run_cont_d;
    logic                         tvalid_q, tvalid_d, tlast_q, tlast_d;
    gen_state_t                   state_q, state_d;

    logic [31:0] wa, ra, rd_val, total_rd;
    logic        aw_hs, w_hs, ar_hs, s_hs, commit, wr_ok, wr_ctrl, start_p, stop_p, go, bad;
    logic        unused_wdata;

    assign wa           = 32'(aw_addr_q);
    assign ra           = 32'(s_axi.araddr);
    assign commit       = aw_held_q && w_held_q && !bvalid_q;
    assign wr_ok        = wr_addr_ok(wa, STATS_EN);
    assign wr_ctrl      = commit && wa == ADDR_CTRL;
    assign start_p      = wr_ctrl && w_data_q[CTRL_START];
    assign stop_p       = wr_ctrl && w_data_q[CTRL_STOP];
    assign s_hs         = tvalid_q && m_axis.tready;
    assign unused_wdata = ^w_data_q;

    // AW/W skid capture, single write response, and one-deep registered read path
    always_comb begin
        aw_hs     = s_axi.awvalid && awready_q;
        w_hs      = s_axi.wvalid && wready_q;
        ar_hs     = s_axi.arvalid && arready_q;
        awready_d = s_axi.awvalid && !awready_q && !aw_held_q && !bvalid_q;
        wready_d  = s_axi.wvalid && !wready_q && !w_held_q && !bvalid_q;
        aw_held_d = !commit && (aw_held_q || aw_hs);
        w_held_d  = !commit && (w_held_q || w_hs);
        aw_addr_d = aw_hs ? s_axi.awaddr : aw_addr_q;
        w_data_d  = w_hs ? s_axi.wdata : w_data_q;
        bvalid_d  = commit || (bvalid_q && !s_axi.bready);
        bresp_d   = commit ? (wr_ok ? RESP_OKAY : RESP_SLVERR) : bresp_q;
        rd_val    = (ra == ADDR_CTRL)   ? {28'd0, cont_q, mode_q, 2'b00} :
                    (ra == ADDR_SEED)   ? 32'(seed_q) :
                    (ra == ADDR_TAPS)   ? 32'(taps_q) :
                    (ra == ADDR_COUNT)  ? 32'(count_q) :
                    (ra == ADDR_STATUS) ? {30'd0, cfg_err_q, state_q != IDLE} :
                    (ra == ADDR_TOTAL)  ? total_rd : 32'd0;
        rvalid_d  = ar_hs || (rvalid_q && !s_axi.rready);
        arready_d = !rvalid_d;
        rdata_d   = ar_hs ? C_AXIL_DATA_WIDTH'(rd_val) : rdata_q;
        rresp_d   = ar_hs ? (rd_addr_ok(ra, STATS_EN) ? RESP_OKAY : RESP_SLVERR) : rresp_q;
    end

    // Configuration registers, updated only by an OKAY write commit
    always_comb begin
        mode_d  = wr_ctrl ? w_data_q[CTRL_MODE] : mode_q;
        cont_d  = wr_ctrl ? w_data_q[CTRL_CONT] : cont_q;
        seed_d  = (commit && wa == ADDR_SEED) ? w_data_q[LFSR_W-1:0] : seed_q;
        taps_d  = (commit && wa == ADDR_TAPS) ? w_data_q[LFSR_W-1:0] : taps_q;
        count_d = (commit && wa == ADDR_COUNT) ? w_data_q[CNT_W-1:0] : count_q;
    end

    lfsr_core #(.LFSR_W(LFSR_W)) u_core (
        .state (lfsr_q),
        .taps  (run_taps_q),
        .mode  (run_mode_q),
        .next  (lfsr_nx)
    );

    // Burst FSM: START snapshots config, each handshake steps the LFSR, STOP drains the pending beat
    always_comb begin
        state_d     = state_q;
        lfsr_d      = s_hs ? lfsr_nx : lfsr_q;
        beats_d     = s_hs ? beats_q + 1'b1 : beats_q;
        run_mode_d  = run_mode_q;
        run_cont_d  = run_cont_q;
        run_taps_d  = run_taps_q;
        run_count_d = run_count_q;
        cfg_err_d   = cfg_err_q;
        go          = state_q == IDLE && start_p && !stop_p;
        bad         = seed_q == '0 || (!cont_d && count_q == '0);
        if (state_q == IDLE) begin
            if (go) begin
                cfg_err_d = bad;
                if (!bad) begin
                    state_d     = RUN;
                    lfsr_d      = seed_q;
                    beats_d     = '0;
                    run_mode_d  = mode_d;
                    run_cont_d  = cont_d;
                    run_taps_d  = taps_q;
                    run_count_d = count_q;
                end
            end
        end else if (state_q == RUN) begin
            if (s_hs && (tlast_q || stop_p)) state_d = IDLE;
            else if (!s_hs && stop_p) state_d = DRAIN;
        end else if (s_hs) begin
            state_d = IDLE;
        end
        tvalid_d = state_d != IDLE;
        tlast_d  = tvalid_d && !run_cont_d && beats_d == run_count_d - 1'b1;
    end

    // State registers; async reset drops tvalid immediately
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
            seed_q      <= LFSR_W'(1);
            taps_q      <= TAPS_INIT;
            count_q     <= CNT_W'(1);
            mode_q      <= 1'b0;
            cont_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            state_q     <= IDLE;
            lfsr_q      <= '0;
            beats_q     <= '0;
            run_mode_q  <= 1'b0;
            run_cont_q  <= 1'b0;
            run_taps_q  <= TAPS_INIT;
            run_count_q <= CNT_W'(1);
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
        end else begin
            aw_addr_q   <= aw_addr_d;
            w_data_q    <= w_data_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            seed_q      <= seed_d;
            taps_q      <= taps_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            cont_q      <= cont_d;
            cfg_err_q   <= cfg_err_d;
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            beats_q     <= beats_d;
            run_mode_q  <= run_mode_d;
            run_cont_q  <= run_cont_d;
            run_taps_q  <= run_taps_d;
            run_count_q <= run_count_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
        end
    end

`ifdef AXIL_LFSR_STATS_EN
    logic [31:0] total_q, total_d;

    // Wrapping count of accepted beats; any write to TOTAL clears it
    always_comb begin
        total_d = (commit && wa == ADDR_TOTAL) ? 32'd0 : total_q + 32'(s_hs);
    end

    // Beat counter register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) total_q <= '0;
        else total_q <= total_d;
    end

    assign total_rd = total_q;
`else
    assign total_rd = 32'd0;
`endif

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign m_axis.tdata  = C_AXIS_DATA_WIDTH'(lfsr_q);
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;

endmodule

// File: tb/tb_axil_lfsr_stream_gen.sv
// tb_axil_lfsr_stream_gen: directed AXI-Lite programming with a queue-based stream model checked every cycle
module tb_axil_lfsr_stream_gen;
    import axil_lfsr_pkg::*;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    axil_if #(.AW(5), .DW(32)) s_axi ();
    axis_if #(.DW(32)) m_axis ();

    axil_lfsr_stream_gen #(
        .LFSR_W(8), .TAPS_RST(32'hB8), .CNT_W(16),
        .C_AXIL_ADDR_WIDTH(5), .C_AXIL_DATA_WIDTH(32), .C_AXIS_DATA_WIDTH(32)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .s_axi  (s_axi),
        .m_axis (m_axis)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int acc = 0;
    int bv_cnt = 0;
    logic prev_stall = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    // Spec-level step: Fibonacci shifts in the tap parity, Galois shifts right and xors taps on a 1 out
    function automatic logic [7:0] nxt(input logic [7:0] s, input logic [7:0] t, input bit galois);
        if (galois) return s[0] ? ((s >> 1) ^ t) : (s >> 1);
        return 8'({s, 1'b0}) | 8'($countones(s & t) % 2);
    endfunction

    task automatic model_burst(input logic [7:0] seed, input logic [7:0] taps, input bit galois,
                               input int n, input bit cont);
        logic [7:0] s = seed;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{s, !cont && i == n - 1});
            s = nxt(s, taps, galois);
        end
    endtask

    // Stream checker: every cycle with tvalid must match the model front; stalls must keep tvalid
    always @(negedge aclk) begin
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("stall_tvalid", m_axis.tvalid, 1);
            if (m_axis.tvalid) begin
                if (exp_q.size() == 0) chk("spurious_tvalid", m_axis.tvalid, 0);
                else begin
                    chk("tdata", m_axis.tdata, 32'(exp_q[0].data));
                    chk("tlast", m_axis.tlast, exp_q[0].last);
                end
            end
            if (s_axi.bvalid) bv_cnt++;
            prev_stall = m_axis.tvalid && !m_axis.tready;
            if (m_axis.tvalid && m_axis.tready) begin
                acc++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input int lead, output logic [1:0] resp);
        int n = 0;
        bit done = 0;
        bit aw_f, w_f;
        resp = 2'b11;
        s_axi.awaddr = 5'(a);
        s_axi.wdata = d;
        s_axi.awvalid = 1'b1;
        while (!done && n < 100) begin
            if (n == lead) s_axi.wvalid = 1'b1;
            @(negedge aclk);
            if (s_axi.bvalid) begin
                resp = s_axi.bresp;
                done = 1;
            end
            aw_f = s_axi.awvalid && s_axi.awready;
            w_f = s_axi.wvalid && s_axi.wready;
            tick();
            if (aw_f) s_axi.awvalid = 1'b0;
            if (w_f) s_axi.wvalid = 1'b0;
            n++;
        end
        s_axi.awvalid = 1'b0;
        s_axi.wvalid = 1'b0;
        chk("write_done", done, 1);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        bit done = 0;
        bit ar_f;
        d = 32'hDEAD_BEEF;
        resp = 2'b11;
        s_axi.araddr = 5'(a);
        s_axi.arvalid = 1'b1;
        while (!done && n < 100) begin
            @(negedge aclk);
            if (s_axi.rvalid) begin
                d = s_axi.rdata;
                resp = s_axi.rresp;
                done = 1;
            end
            ar_f = s_axi.arvalid && s_axi.arready;
            tick();
            if (ar_f) s_axi.arvalid = 1'b0;
            n++;
        end
        s_axi.arvalid = 1'b0;
        chk("read_done", done, 1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] er);
        logic [1:0] r;
        axi_write(a, d, 0, r);
        chk($sformatf("bresp_%0h", a), 32'(r), 32'(er));
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        logic [31:0] d;
        logic [1:0] r;
        axi_read(a, d, r);
        chk({nm, "_data"}, d, ed);
        chk({nm, "_resp"}, 32'(r), 32'(er));
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        chk({nm, "_drained"}, exp_q.size(), 0);
        repeat (3) tick();
        chk({nm, "_idle_tvalid"}, m_axis.tvalid, 0);
    endtask

    logic [7:0] fib_lit [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    logic [7:0] gal_lit [5] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17};
    logic       pat     [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int base, n, bv0;
        logic [1:0] r;
        s_axi.awaddr = '0; s_axi.awvalid = 0; s_axi.wdata = '0; s_axi.wvalid = 0;
        s_axi.bready = 1; s_axi.araddr = '0; s_axi.arvalid = 0; s_axi.rready = 1;
        m_axis.tready = 1;

        @(negedge aclk);
        chk("rst_handshakes", {s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.arready,
                                s_axi.rvalid, m_axis.tvalid, m_axis.tlast}, 0);
        chk("rst_tdata", m_axis.tdata, 0);
        chk("rst_resp_rdata", {s_axi.bresp, s_axi.rresp} | s_axi.rdata, 0);
        tick();
        areset = 1'b0;
        tick();

        rd("rst_seed", ADDR_SEED, 32'h01, RESP_OKAY);
        rd("rst_taps", ADDR_TAPS, 32'hB8, RESP_OKAY);
        rd("rst_count", ADDR_COUNT, 32'h01, RESP_OKAY);
        rd("rst_ctrl", ADDR_CTRL, 32'h0, RESP_OKAY);
        rd("rst_status", ADDR_STATUS, 32'h0, RESP_OKAY);

        // Fibonacci counted burst of 5
        wr(ADDR_COUNT, 5, RESP_OKAY);
        model_burst(8'h01, 8'hB8, 0, 5, 0);
        for (int i = 0; i < 5; i++) chk("fib_model_pin", exp_q[i].data, fib_lit[i]);
        chk("fib_model_last_pin", exp_q[4].last, 1);
        wr(ADDR_CTRL, 32'h1, RESP_OKAY);
        wait_done("fib");
        rd("fib_status", ADDR_STATUS, 32'h0, RESP_OKAY);

        // Galois counted burst of 5
        model_burst(8'h01, 8'hB8, 1, 5, 0);
        for (int i = 0; i < 5; i++) chk("gal_model_pin", exp_q[i].data, gal_lit[i]);
        wr(ADDR_CTRL, 32'h5, RESP_OKAY);
        wait_done("gal");
        rd("gal_ctrl", ADDR_CTRL, 32'h4, RESP_OKAY);

        // Backpressure: COUNT=4 with tready pattern 1-0-0-1
        wr(ADDR_COUNT, 4, RESP_OKAY);
        base = acc;
        model_burst(8'h01, 8'hB8, 0, 4, 0);
        wr(ADDR_CTRL, 32'h1, RESP_OKAY);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            m_axis.tready = pat[n % 4];
            tick();
            n++;
        end
        m_axis.tready = 1;
        wait_done("stall");
        chk("stall_beat_count", acc - base, 4);

        // Free-run, STOP while 0x08 is stalled
        model_burst(8'h01, 8'hB8, 0, 16, 1);
        base = acc;
        wr(ADDR_CTRL, 32'h9, RESP_OKAY);
        n = 0;
        while (acc - base < 3 && n < 100) begin
            tick();
            n++;
        end
        m_axis.tready = 0;
        @(negedge aclk);
        chk("stop_pending_data", m_axis.tdata, 32'h08);
        tick();
        wr(ADDR_CTRL, 32'hA, RESP_OKAY);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        repeat (3) tick();
        chk("drain_hold_tvalid", m_axis.tvalid, 1);
        chk("drain_hold_tdata", m_axis.tdata, 32'h08);
        chk("drain_no_tlast", m_axis.tlast, 0);
        m_axis.tready = 1;
        wait_done("drain");
        chk("drain_beat_count", acc - base, 4);
        rd("drain_status", ADDR_STATUS, 32'h0, RESP_OKAY);

        // Zero seed -> CFG_ERR, then a good start clears it
        wr(ADDR_SEED, 0, RESP_OKAY);
        wr(ADDR_CTRL, 32'h1, RESP_OKAY);
        repeat (5) tick();
        chk("cfgerr_no_tvalid", m_axis.tvalid, 0);
        rd("cfgerr_status", ADDR_STATUS, 32'h2, RESP_OKAY);
        wr(ADDR_SEED, 1, RESP_OKAY);
        model_burst(8'h01, 8'hB8, 0, 4, 0);
        wr(ADDR_CTRL, 32'h1, RESP_OKAY);
        wait_done("cfgok");
        rd("cfgok_status", ADDR_STATUS, 32'h0, RESP_OKAY);

        // COUNT=1: single beat carrying tlast
        wr(ADDR_COUNT, 1, RESP_OKAY);
        model_burst(8'h01, 8'hB8, 0, 1, 0);
        wr(ADDR_CTRL, 32'h1, RESP_OKAY);
        wait_done("count1");

        // AW three cycles ahead of W -> one OKAY response
        bv0 = bv_cnt;
        axi_write(ADDR_COUNT, 7, 3, r);
        chk("lead_bresp", 32'(r), 32'(RESP_OKAY));
        repeat (2) tick();
        chk("lead_single_bvalid", bv_cnt - bv0, 1);
        rd("lead_count", ADDR_COUNT, 32'h7, RESP_OKAY);
        wr(ADDR_STATUS, 32'h3, RESP_SLVERR);
        rd("status_unchanged", ADDR_STATUS, 32'h0, RESP_OKAY);
        rd("unmapped_1c", 32'h1C, 32'h0, RESP_SLVERR);

`ifdef AXIL_LFSR_STATS_EN
        rd("total", ADDR_TOTAL, 32'(acc), RESP_OKAY);
        wr(ADDR_TOTAL, 32'h5, RESP_OKAY);
        rd("total_cleared", ADDR_TOTAL, 32'h0, RESP_OKAY);
`else
        rd("total_absent", ADDR_TOTAL, 32'h0, RESP_SLVERR);
        wr(ADDR_TOTAL, 32'h5, RESP_SLVERR);
`endif

        // Asynchronous reset in the middle of a stalled burst
        wr(ADDR_SEED, 3, RESP_OKAY);
        wr(ADDR_COUNT, 20, RESP_OKAY);
        m_axis.tready = 0;
        model_burst(8'h03, 8'hB8, 0, 20, 0);
        wr(ADDR_CTRL, 32'h1, RESP_OKAY);
        repeat (2) tick();
        chk("midrst_first_beat", m_axis.tdata, 32'h03);
        #2 areset = 1'b1;
        #1 chk("midrst_tvalid_async", m_axis.tvalid, 0);
        exp_q.delete();
        repeat (2) tick();
        areset = 1'b0;
        m_axis.tready = 1;
        tick();
        rd("midrst_seed", ADDR_SEED, 32'h01, RESP_OKAY);
        rd("midrst_count", ADDR_COUNT, 32'h01, RESP_OKAY);
        rd("midrst_status", ADDR_STATUS, 32'h0, RESP_OKAY);
        repeat (3) tick();
        chk("midrst_idle_tvalid", m_axis.tvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
